// File: rtl/interrupt_exception_sequencer_pkg.sv
// Shared types and constants for the interrupt exception sequencer.
package interrupt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BND,
        ACK,
        WAIT_VEC,
        PUSH_PC,
        PUSH_CCR,
        FETCH_VEC,
        LOAD
    } int_seq_state_e;

    localparam int         CCR_I_BIT       = 7;
    localparam int         EXR_T_BIT       = 7;
    localparam logic [2:0] NMI_PRIORITY    = 3'd7;
    localparam int         VEC_ENTRY_SHIFT = 2;

    // Mode 2 raises the EXR mask to the accepted level and clears trace.
    function automatic logic [7:0] exr_update(input logic [7:0] exr, input logic mode2,
                                              input logic nmi, input logic [2:0] prio);
        logic [7:0] r;
        r = exr;
        if (mode2) begin
            r[EXR_T_BIT] = 1'b0;
            r[2:0]       = nmi ? NMI_PRIORITY : prio;
        end
        return r;
    endfunction

endpackage

// File: rtl/interrupt_exception_sequencer_if.sv
// Memory bus between the sequencer (master) and the CPU stack/fetch path (slave).
interface interrupt_exception_sequencer_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/interrupt_exception_sequencer_mem_port.sv
// Request/ack holding register: keeps the bus stable until the slave acks.
module int_mem_port #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [DATA_W-1:0] issue_wdata,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    interrupt_exception_sequencer_if.master mem
);

    // A new issue on the ack cycle chains the next access without a gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else if (issue) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= issue_we;
            mem.mem_addr  <= issue_addr;
            mem.mem_wdata <= issue_wdata;
        end else if (mem.mem_req && mem.mem_ack) begin
            mem.mem_req   <= 1'b0;
        end
    end

    assign done  = mem.mem_req & mem.mem_ack;
    assign rdata = mem.mem_rdata;

endmodule

// File: rtl/interrupt_exception_sequencer.sv
// Interrupt entry sequencer: acknowledge, stack PC and CCR/EXR, fetch vector, load core.
module interrupt_exception_sequencer
    import interrupt_pkg::*;
#(
    parameter int              ADDR_W      = 24,
    parameter int              DATA_W      = 32,
    parameter logic [ADDR_W-1:0] VEC_BASE  = 24'h000000,
    parameter int              ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              interrupt_request,
    input  logic              NMI_req,
    input  logic              INTM1,
    input  logic              instr_boundary,
    output logic              int_ack,
    input  logic              vector_valid,
    input  logic [7:0]        vector_num,
    input  logic [2:0]        vector_priority,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] sp_in,
    input  logic [7:0]        ccr_in,
    input  logic [7:0]        exr_in,
    output logic              core_stall,
    output logic              pc_load,
    output logic [ADDR_W-1:0] new_pc,
    output logic [ADDR_W-1:0] new_sp,
    output logic [7:0]        new_ccr,
    output logic [7:0]        new_exr,
    output logic              spurious,
    interrupt_exception_sequencer_if.master mem
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    int_seq_state_e   state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             timeout;
    logic [ADDR_W-1:0] pc_q, sp_q;
    logic [7:0]       ccr_q, exr_q, vec_q;
    logic [2:0]       prio_q;
    logic             nmi_q;
    logic             issue, issue_we, done;
    logic [ADDR_W-1:0] issue_addr;
    logic [DATA_W-1:0] issue_wdata, rdata;
    logic             rdata_unused;

    assign timeout      = (cnt == CNT_W'(ACK_TIMEOUT));
    assign rdata_unused = ^rdata[DATA_W-1:ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state  = state;
        issue       = 1'b0;
        issue_we    = 1'b0;
        issue_addr  = '0;
        issue_wdata = '0;
        int_ack     = (state == ACK);
        pc_load     = (state == LOAD);
        core_stall  = (state != IDLE) && (state != WAIT_BND);
        spurious    = 1'b0;
        case (state)
            IDLE:      if (interrupt_request) next_state = WAIT_BND;
            WAIT_BND: begin
                if (!interrupt_request)  next_state = IDLE;
                else if (instr_boundary) next_state = ACK;
            end
            ACK:       next_state = WAIT_VEC;
            WAIT_VEC: begin
                if (vector_valid) begin
                    next_state  = PUSH_PC;
                    issue       = 1'b1;
                    issue_we    = 1'b1;
                    issue_addr  = sp_q - ADDR_W'(4);
                    issue_wdata = DATA_W'(pc_q);
                end else if (timeout) begin
                    next_state = IDLE;
                    spurious   = 1'b1;
                end
            end
            PUSH_PC: if (done) begin
                next_state  = PUSH_CCR;
                issue       = 1'b1;
                issue_we    = 1'b1;
                issue_addr  = sp_q - ADDR_W'(8);
                issue_wdata = DATA_W'({exr_q, ccr_q});
            end
            PUSH_CCR: if (done) begin
                next_state = FETCH_VEC;
                issue      = 1'b1;
                issue_addr = VEC_BASE + (ADDR_W'(vec_q) << VEC_ENTRY_SHIFT);
            end
            FETCH_VEC: if (done) next_state = LOAD;
            LOAD:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Timeout counter and core-facing results are control-visible, so they reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            new_pc  <= '0;
            new_sp  <= '0;
            new_ccr <= '0;
            new_exr <= '0;
        end else begin
            if (state == ACK)                        cnt <= '0;
            else if (state == WAIT_VEC && !vector_valid) cnt <= cnt + 1'b1;
            if (state == FETCH_VEC && done) begin
                new_pc  <= rdata[ADDR_W-1:0];
                new_sp  <= sp_q - ADDR_W'(8);
                new_ccr <= ccr_q | (8'h01 << CCR_I_BIT);
                new_exr <= exr_update(exr_q, INTM1, nmi_q, prio_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == WAIT_BND && interrupt_request && instr_boundary) begin
            pc_q  <= pc_in;
            sp_q  <= sp_in;
            ccr_q <= ccr_in;
            exr_q <= exr_in;
            nmi_q <= NMI_req;
        end
        if (state == WAIT_VEC && vector_valid) begin
            vec_q  <= vector_num;
            prio_q <= vector_priority;
        end
    end

    int_mem_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem_port (
        .clk         (clk),
        .rst         (rst),
        .issue       (issue),
        .issue_we    (issue_we),
        .issue_addr  (issue_addr),
        .issue_wdata (issue_wdata),
        .done        (done),
        .rdata       (rdata),
        .mem         (mem)
    );

endmodule

// File: tb/tb_interrupt_exception_sequencer.sv
// Scoreboard bench: the driver queues expected output events, a monitor checks them.
module tb_interrupt_exception_sequencer;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;
    localparam int ACK_TO = 15;
    localparam int EV_ACK = 0, EV_MEM = 1, EV_LOAD = 2, EV_SPUR = 3;

    typedef struct {
        int          kind;
        int          cyc;
        logic        we;
        logic [23:0] addr;
        logic [31:0] data;
        logic [23:0] sp;
        logic [7:0]  ccr;
        logic [7:0]  exr;
    } ev_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        interrupt_request = 1'b0, NMI_req = 1'b0, INTM1 = 1'b0;
    logic        instr_boundary = 1'b0, vector_valid = 1'b0;
    logic [7:0]  vector_num = '0;
    logic [2:0]  vector_priority = '0;
    logic [23:0] pc_in = '0, sp_in = '0;
    logic [7:0]  ccr_in = '0, exr_in = '0;
    logic        int_ack, core_stall, pc_load, spurious;
    logic [23:0] new_pc, new_sp;
    logic [7:0]  new_ccr, new_exr;

    int   cyc = 0;
    int   tests = 0, fails = 0;
    int   mem_delay = 0, mem_wait = 0;
    ev_t  exp_q[$];
    logic        pend = 1'b0, pend_we;
    logic [23:0] pend_addr;
    logic [31:0] pend_wdata;

    interrupt_exception_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

    interrupt_exception_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .VEC_BASE(24'h000000), .ACK_TIMEOUT(ACK_TO)
    ) dut (
        .clk(clk), .rst(rst), .interrupt_request(interrupt_request), .NMI_req(NMI_req),
        .INTM1(INTM1), .instr_boundary(instr_boundary), .int_ack(int_ack),
        .vector_valid(vector_valid), .vector_num(vector_num), .vector_priority(vector_priority),
        .pc_in(pc_in), .sp_in(sp_in), .ccr_in(ccr_in), .exr_in(exr_in),
        .core_stall(core_stall), .pc_load(pc_load), .new_pc(new_pc), .new_sp(new_sp),
        .new_ccr(new_ccr), .new_exr(new_exr), .spurious(spurious), .mem(mem_bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (tests=%0d)", tests);
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] handler(input logic [23:0] a);
        return a * 24'd37 + 24'h4B0011;
    endfunction

    function automatic logic [7:0] exp_exr(input logic [7:0] exr, input logic m2,
                                           input logic nmi, input logic [2:0] prio);
        if (!m2) return exr;
        return (exr & 8'h78) | (nmi ? 8'd7 : {5'd0, prio});
    endfunction

    function automatic ev_t mk_ev(input int kind, input int c, input logic we,
                                  input logic [23:0] a, input logic [31:0] d,
                                  input logic [23:0] sp, input logic [7:0] ccr, input logic [7:0] exr);
        ev_t e;
        e.kind = kind; e.cyc = c; e.we = we; e.addr = a; e.data = d;
        e.sp = sp; e.ccr = ccr; e.exr = exr;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic take(input int kind, output ev_t e, output bit ok);
        tests++;
        ok = 1'b0;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind %0d, expected none (cycle %0d)", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind) begin
                fails++;
                $display("FAIL event_order: got kind %0d, expected kind %0d (cycle %0d)", kind, e.kind, cyc);
            end else ok = 1'b1;
        end
    endtask

    // Memory slave: acks each access on its (mem_delay+1)-th request cycle.
    initial begin
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;
    end
    always begin
        @(posedge clk); #1;
        mem_bus.mem_ack = 1'b0;
        if (rst || !mem_bus.mem_req) mem_wait = 0;
        else if (mem_wait >= mem_delay) begin
            mem_bus.mem_ack   = 1'b1;
            mem_bus.mem_rdata = {8'hA5, handler(mem_bus.mem_addr)};
            mem_wait = 0;
        end else mem_wait++;
    end

    always @(negedge clk) begin
        ev_t e;
        bit  ok;
        if (rst) pend = 1'b0;
        else begin
            if (int_ack) begin
                take(EV_ACK, e, ok);
                if (ok) begin
                    check("ack_cycle", cyc, e.cyc);
                    check("ack_stall", core_stall, 1);
                end
            end
            if (mem_bus.mem_req && mem_bus.mem_ack) begin
                take(EV_MEM, e, ok);
                if (ok) begin
                    check("mem_we", mem_bus.mem_we, e.we);
                    check("mem_addr", mem_bus.mem_addr, e.addr);
                    if (e.we) check("mem_wdata", mem_bus.mem_wdata, e.data);
                    check("mem_stall", core_stall, 1);
                end
            end
            if (pc_load) begin
                take(EV_LOAD, e, ok);
                if (ok) begin
                    check("new_pc", new_pc, e.addr);
                    check("new_sp", new_sp, e.sp);
                    check("new_ccr", new_ccr, e.ccr);
                    check("new_exr", new_exr, e.exr);
                end
            end
            if (spurious) begin
                take(EV_SPUR, e, ok);
                if (ok) check("spurious_cycle", cyc, e.cyc);
            end
            if (pend && mem_bus.mem_req) begin
                check("hold_we", mem_bus.mem_we, pend_we);
                check("hold_addr", mem_bus.mem_addr, pend_addr);
                check("hold_wdata", mem_bus.mem_wdata, pend_wdata);
            end
            pend       = mem_bus.mem_req && !mem_bus.mem_ack;
            pend_we    = mem_bus.mem_we;
            pend_addr  = mem_bus.mem_addr;
            pend_wdata = mem_bus.mem_wdata;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string p);
        check({p, "_int_ack"}, int_ack, 0);
        check({p, "_mem_req"}, mem_bus.mem_req, 0);
        check({p, "_mem_we"}, mem_bus.mem_we, 0);
        check({p, "_mem_addr"}, mem_bus.mem_addr, 0);
        check({p, "_mem_wdata"}, mem_bus.mem_wdata, 0);
        check({p, "_core_stall"}, core_stall, 0);
        check({p, "_pc_load"}, pc_load, 0);
        check({p, "_new_pc"}, new_pc, 0);
        check({p, "_new_sp"}, new_sp, 0);
        check({p, "_new_ccr"}, new_ccr, 0);
        check({p, "_new_exr"}, new_exr, 0);
        check({p, "_spurious"}, spurious, 0);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            instr_boundary = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        instr_boundary = 1'b0;
        check("drain_pending", exp_q.size(), 0);
        if (exp_q.size() != 0) begin
            exp_q.delete();
            rst = 1'b1; step(); step(); rst = 1'b0;
        end
    endtask

    // vld_dly = 0 means the controller never answers the acknowledge.
    task automatic run_txn(input int bnd_dly, input int vld_dly, input logic [7:0] vec,
                           input logic [2:0] prio, input logic nmi, input logic m2,
                           input logic [23:0] pc, input logic [23:0] sp,
                           input logic [7:0] ccr, input logic [7:0] exr, input int mdly);
        int ta;
        mem_delay = mdly;
        INTM1 = m2;
        interrupt_request = 1'b1;
        repeat (bnd_dly) step();
        instr_boundary = 1'b1;
        pc_in = pc; sp_in = sp; ccr_in = ccr; exr_in = exr; NMI_req = nmi;
        ta = cyc + 1;
        exp_q.push_back(mk_ev(EV_ACK, ta, 0, 0, 0, 0, 0, 0));
        if (vld_dly == 0) begin
            exp_q.push_back(mk_ev(EV_SPUR, ta + 1 + ACK_TO, 0, 0, 0, 0, 0, 0));
        end else begin
            exp_q.push_back(mk_ev(EV_MEM, 0, 1, sp - 24'd4, {8'd0, pc}, 0, 0, 0));
            exp_q.push_back(mk_ev(EV_MEM, 0, 1, sp - 24'd8, {16'd0, exr, ccr}, 0, 0, 0));
            exp_q.push_back(mk_ev(EV_MEM, 0, 0, 24'(vec) * 24'd4, 0, 0, 0, 0));
            exp_q.push_back(mk_ev(EV_LOAD, 0, 0, handler(24'(vec) * 24'd4), 0,
                                  sp - 24'd8, ccr | 8'h80, exp_exr(exr, m2, nmi, prio)));
        end
        step();
        instr_boundary = 1'b0; interrupt_request = 1'b0;
        pc_in = 24'($urandom); sp_in = 24'($urandom);
        ccr_in = 8'($urandom); exr_in = 8'($urandom); NMI_req = 1'($urandom);
        if (vld_dly > 0) begin
            repeat (vld_dly) step();
            vector_valid = 1'b1; vector_num = vec; vector_priority = prio;
            step();
            vector_valid = 1'b0; vector_num = 8'($urandom); vector_priority = 3'($urandom);
        end
        wait_drain(300);
        step();
        check("stall_released", core_stall, 0);
    endtask

    task automatic run_abort(input int k);
        int bad = 0;
        interrupt_request = 1'b1;
        repeat (k) step();
        interrupt_request = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (core_stall || mem_bus.mem_req || int_ack) bad++;
            step();
        end
        check("abort_quiet", bad, 0);
    endtask

    task automatic run_reset_mid();
        int n = 0;
        mem_delay = 5;
        INTM1 = 1'b1;
        interrupt_request = 1'b1;
        step();
        instr_boundary = 1'b1;
        pc_in = 24'hABCDEF; sp_in = 24'h000800; ccr_in = 8'h11; exr_in = 8'h22; NMI_req = 1'b0;
        exp_q.push_back(mk_ev(EV_ACK, cyc + 1, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk_ev(EV_MEM, 0, 1, 24'h0007FC, 32'h00ABCDEF, 0, 0, 0));
        step();
        instr_boundary = 1'b0; interrupt_request = 1'b0;
        step();
        vector_valid = 1'b1; vector_num = 8'd9; vector_priority = 3'd3;
        step();
        vector_valid = 1'b0;
        while (!(mem_bus.mem_req && mem_bus.mem_addr == 24'h0007F8) && n < 100) begin
            step();
            n++;
        end
        check("reach_push_ccr", 32'(n < 100), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check_zero("mid_rst");
        check("mid_rst_flush", exp_q.size(), 0);
        exp_q.delete();
        step();
    endtask

    initial begin
        int sel;
        rst = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check_zero("reset");
        step();
        rst = 1'b0;
        step();

        run_txn(3, 2, 8'd64, 3'd5, 1'b0, 1'b1, 24'h123456, 24'h001000, 8'h00, 8'h80, 0);
        run_txn(1, 1, 8'd7, 3'd2, 1'b1, 1'b1, 24'h00ABCD, 24'h00F000, 8'h04, 8'hFA, 1);
        run_txn(2, 3, 8'd7, 3'd2, 1'b1, 1'b0, 24'h00ABCD, 24'h00F000, 8'h05, 8'hC3, 0);
        run_abort(2);
        run_txn(2, 0, 8'd0, 3'd0, 1'b0, 1'b1, 24'h111111, 24'h002000, 8'h00, 8'h00, 0);
        run_txn(1, 16, 8'd255, 3'd6, 1'b0, 1'b1, 24'hFEDCBA, 24'h000004, 8'h7F, 8'h07, 2);
        run_txn(4, 5, 8'd33, 3'd1, 1'b0, 1'b1, 24'h0F0F0F, 24'h800000, 8'h3C, 8'hFF, 5);
        run_reset_mid();
        run_txn(2, 2, 8'd12, 3'd4, 1'b0, 1'b1, 24'h222222, 24'h003000, 8'h01, 8'h00, 0);

        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0) run_abort(int'($urandom_range(1, 3)));
            else run_txn(int'($urandom_range(1, 4)),
                         (sel == 1) ? 0 : int'($urandom_range(1, 16)),
                         8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                         24'($urandom),
                         (sel == 2) ? 24'($urandom_range(0, 7)) : 24'($urandom),
                         8'($urandom), 8'($urandom), int'($urandom_range(0, 5)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/interrupt_exception_sequencer.md
Name: interrupt_exception_sequencer

Overview:
- CPU-side responder to the interrupt controller's `interrupt_request` line.
- Waits for an instruction boundary, then acknowledges the request and takes the vector number and priority from the controller.
- Pushes PC and CCR/EXR to the stack, fetches the handler address from the vector table, and hands the new PC, SP, CCR and EXR to the CPU core.
- Sits between the interrupt controller output stage and the CPU fetch/stack units.

Parameters:
- ADDR_W, 24, address width of PC, SP and memory bus.
- DATA_W, 32, memory data width; one stack push per word.
- VEC_BASE, 24'h000000, vector table base address; each entry is 4 bytes.
- ACK_TIMEOUT, 15, cycles to wait for `vector_valid` after `int_ack` before abort.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- interrupt_request  in  1  level request from the controller (NMI already merged).
- NMI_req  in  1  NMI is the source; qualifies priority.
- INTM1  in  1  interrupt control mode 2 (EXR mask update enabled).
- instr_boundary  in  1  core is at an instruction boundary this cycle.
- int_ack  out  1  single-cycle acknowledge to the controller.
- vector_valid  in  1  `vector_num` and `vector_priority` are valid.
- vector_num  in  8  vector number (0..255).
- vector_priority  in  3  priority of the accepted source.
- pc_in  in  ADDR_W  return PC.
- sp_in  in  ADDR_W  current SP.
- ccr_in  in  8  current CCR.
- exr_in  in  8  current EXR.
- mem_req  out  1  memory request; held until `mem_ack`.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data; valid with `mem_ack`.
- mem_ack  in  1  one-cycle completion.
- core_stall  out  1  holds the core while the sequence runs.
- pc_load  out  1  one-cycle pulse; `new_pc`/`new_sp`/`new_ccr`/`new_exr` valid.
- new_pc  out  ADDR_W  handler address.
- new_sp  out  ADDR_W  `sp_in` − 8.
- new_ccr  out  8  CCR with I (bit 7) set.
- new_exr  out  8  updated EXR.
- spurious  out  1  one-cycle pulse on acknowledge timeout.

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Reset in any state aborts at once; `mem_req` drops the same cycle.
- IDLE: on `interrupt_request`=1 go to WAIT_BND.
- WAIT_BND:
  - `interrupt_request`=0 → IDLE, no ack.
  - `instr_boundary`=1 → ACK; latch `pc_in`, `sp_in`, `ccr_in`, `exr_in`, `NMI_req`.
  - `core_stall` asserts from the ACK cycle onward.
- ACK: `int_ack`=1 for exactly one cycle → WAIT_VEC; clear counter.
- WAIT_VEC:
  - `vector_valid` → latch vector/priority → PUSH_PC.
  - Otherwise counter+1; if counter = ACK_TIMEOUT, pulse `spurious` → IDLE, no stack writes.
  - `vector_valid` in the same cycle as the timeout compare wins.
- PUSH_PC: write, addr = sp−4, wdata = zero-extended PC → PUSH_CCR on `mem_ack`.
- PUSH_CCR: write, addr = sp−8, wdata = {EXR, CCR} in bits [15:0], upper bits 0 → FETCH_VEC on `mem_ack`.
- FETCH_VEC: read, addr = VEC_BASE + (vector_num << 2), truncated to ADDR_W → LOAD on `mem_ack`; capture `mem_rdata[ADDR_W-1:0]`.
- LOAD: `pc_load`=1 for one cycle; `core_stall` drops the next cycle → IDLE.
- Memory outputs are stable while `mem_req`=1 and `mem_ack`=0. `mem_req` deasserts the cycle after `mem_ack`. Back-to-back accesses are allowed.
- new_ccr = CCR | 8'h80.
- new_exr when INTM1=1:
  - EXR[2:0] = 3'd7 if the latched NMI is set, else `vector_priority`.
  - EXR[7] (T) = 0.
  - Other bits unchanged.
- new_exr when INTM1=0: equals latched EXR.
- SP wrap: subtraction is modulo 2^ADDR_W.
- `interrupt_request` is ignored after ACK. A new request during the sequence is serviced only after returning to IDLE, so latency to ack is ≥1 cycle after LOAD.

Decomposition:
- Shared package `interrupt_pkg`:
  - `int_seq_state_e` enum (IDLE, WAIT_BND, ACK, WAIT_VEC, PUSH_PC, PUSH_CCR, FETCH_VEC, LOAD).
  - Constants CCR_I_BIT=7, EXR_T_BIT=7, NMI_PRIORITY=3'd7, VEC_ENTRY_SHIFT=2.
- One natural sub-module: `int_mem_port`, the request/ack holding register for the memory handshake.

Test Plan:
- Request=1, boundary after 3 cycles, vector_valid 2 cycles after ack (vector 64, priority 5), INTM1=1, SP=0x1000, EXR=0x80 → single `int_ack`; writes at 0xFFC then 0xFF8; read at 0x100; `new_exr`=0x05, `new_sp`=0xFF8, one `pc_load`.
- NMI_req=1 with vector 7, INTM1=1 → `new_exr[2:0]`=7; INTM1=0 → `new_exr`=`exr_in`, `new_ccr` I bit set.
- Request drops before `instr_boundary` → no `int_ack`, no `mem_req`, `core_stall` stays 0.
- No `vector_valid` after ack → `spurious` pulse 15 cycles after WAIT_VEC entry; no memory access; back to IDLE.
- `mem_ack` delayed 5 cycles per access → `mem_addr`/`mem_wdata` stable throughout; exactly three accesses.
- `rst` asserted during PUSH_CCR → next cycle all outputs 0; a fresh request then runs a full sequence.
